// File: rtl/strip_fit_scheduler_pkg.sv
// Shared widths, sentinels and FSM state type for the strip best-fit scheduler.
package strip_pkg;
    localparam int ID_W  = 4;
    localparam int WID_W = 7;
    localparam logic [ID_W-1:0]  ID_NONE   = 4'hF;
    localparam logic [WID_W-1:0] USED_NONE = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_RESP
    } state_t;
endpackage

// File: rtl/strip_fit_scheduler_min3.sv
// Combinational min-of-3 among fitting strips; lowest index wins ties.
module strip_min3_fit
    import strip_pkg::*;
(
    input  logic [2:0][ID_W-1:0]  id_i,
    input  logic [2:0][WID_W-1:0] used_i,
    input  logic [2:0]            fit_i,
    output logic [ID_W-1:0]       win_id_o,
    output logic [WID_W-1:0]      win_used_o,
    output logic                  any_fit_o
);
    logic [ID_W-1:0]  best_id;
    logic [WID_W-1:0] best_used;
    logic             found;

    always_comb begin
        best_id   = ID_NONE;
        best_used = USED_NONE;
        found     = 1'b0;
        // Ascending scan with strict '<' keeps the lowest id on equal widths.
        for (int unsigned k = 0; k < 3; k++) begin
            if (fit_i[k] && (!found || used_i[k] < best_used)) begin
                best_id   = id_i[k];
                best_used = used_i[k];
                found     = 1'b1;
            end
        end
        win_id_o   = best_id;
        win_used_o = best_used;
        any_fit_o  = found;
    end
endmodule

// File: rtl/strip_fit_scheduler.sv
// Best-fit strip allocator: scans three strips per cycle, commits the winner, and
// returns the chosen strip on a valid/ready response channel.
module strip_fit_scheduler
    import strip_pkg::*;
#(
    parameter int NUM_STRIPS = 12,
    parameter int STRIP_CAP  = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             req_valid,
    input  logic [WID_W-1:0] req_width,
    output logic             req_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_ok,
    output logic [ID_W-1:0]  resp_id,
    output logic [WID_W-1:0] resp_width,
    output logic             busy
);
    localparam int NG    = NUM_STRIPS / 3;
    localparam int GRP_W = 3;

    logic [WID_W-1:0] table_q [NUM_STRIPS];
    state_t           state_q;
    logic [WID_W-1:0] width_q;
    logic [GRP_W-1:0] grp_q;
    logic [ID_W-1:0]  best_id_q, best_id_d;
    logic [WID_W-1:0] best_used_q, best_used_d;
    logic             resp_valid_q, resp_ok_q;
    logic [ID_W-1:0]  resp_id_q;
    logic [WID_W-1:0] resp_width_q;

    logic [ID_W-1:0]        base;
    logic [2:0][ID_W-1:0]   cand_id;
    logic [2:0][WID_W-1:0]  cand_used;
    logic [2:0]             cand_fit;
    logic [ID_W-1:0]        win_id;
    logic [WID_W-1:0]       win_used;
    logic                   any_fit;
    logic                   last_grp;
    logic [WID_W-1:0]       commit_sum;

    always_comb begin
        base = ID_W'(grp_q) * ID_W'(3);
        for (int unsigned k = 0; k < 3; k++) begin
            cand_id[k]   = base + ID_W'(k);
            cand_used[k] = table_q[cand_id[k]];
            // Widened add so used + width cannot wrap before the capacity compare.
            cand_fit[k]  = ({1'b0, cand_used[k]} + {1'b0, width_q}) <= (WID_W+1)'(STRIP_CAP);
        end
    end

    strip_min3_fit u_min3 (
        .id_i       (cand_id),
        .used_i     (cand_used),
        .fit_i      (cand_fit),
        .win_id_o   (win_id),
        .win_used_o (win_used),
        .any_fit_o  (any_fit)
    );

    always_comb begin
        best_id_d   = best_id_q;
        best_used_d = best_used_q;
        if (any_fit && win_used < best_used_q) begin
            best_id_d   = win_id;
            best_used_d = win_used;
        end
        last_grp   = (grp_q == GRP_W'(NG - 1));
        commit_sum = best_used_d + width_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_STRIPS; i++) table_q[i] <= '0;
            state_q      <= S_IDLE;
            width_q      <= '0;
            grp_q        <= '0;
            best_id_q    <= ID_NONE;
            best_used_q  <= USED_NONE;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            resp_id_q    <= ID_NONE;
            resp_width_q <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < NUM_STRIPS; i++) table_q[i] <= '0;
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        width_q     <= req_width;
                        best_id_q   <= ID_NONE;
                        best_used_q <= USED_NONE;
                        grp_q       <= '0;
                        state_q     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    best_id_q   <= best_id_d;
                    best_used_q <= best_used_d;
                    grp_q       <= grp_q + 1'b1;
                    if (last_grp) begin
                        if (best_id_d != ID_NONE) begin
                            table_q[best_id_d] <= commit_sum;
                            resp_ok_q    <= 1'b1;
                            resp_id_q    <= best_id_d;
                            resp_width_q <= commit_sum;
                        end else begin
                            resp_ok_q    <= 1'b0;
                            resp_id_q    <= ID_NONE;
                            resp_width_q <= width_q;
                        end
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE) && !clear;
    assign busy       = (state_q != S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_ok    = resp_ok_q;
    assign resp_id    = resp_id_q;
    assign resp_width = resp_width_q;
endmodule

// File: tb/tb_strip_fit_scheduler.sv
// Scoreboard bench for strip_fit_scheduler: reference best-fit model, queue, monitor.
module tb_strip_fit_scheduler;
    localparam int NS  = 12;
    localparam int CAP = 100;
    localparam int LAT = NS / 3;

    typedef struct packed {
        logic       ok;
        logic [3:0] id;
        logic [6:0] w;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       req_valid = 1'b0;
    logic [6:0] req_width = '0;
    logic       req_ready;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_ok;
    logic [3:0] resp_id;
    logic [6:0] resp_width;
    logic       busy;

    int   checks = 0;
    int   errors = 0;
    int   used [NS];
    exp_t exp_q [$];
    logic hold_rdy = 1'b0;

    strip_fit_scheduler #(.NUM_STRIPS(NS), .STRIP_CAP(CAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_width  (req_width),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_ok    (resp_ok),
        .resp_id    (resp_id),
        .resp_width (resp_width),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: smallest used width among all fitting strips, lowest index on ties.
    function automatic exp_t model_place(input int w);
        int   best = -1;
        exp_t e;
        for (int i = 0; i < NS; i++)
            if (used[i] + w <= CAP && (best < 0 || used[i] < used[best])) best = i;
        if (best < 0) begin
            e.ok = 1'b0; e.id = 4'hF; e.w = 7'(w);
        end else begin
            used[best] += w;
            e.ok = 1'b1; e.id = 4'(best); e.w = 7'(used[best]);
        end
        return e;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NS; i++) used[i] = 0;
    endfunction

    initial begin
        resp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            resp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp actual id=%0d expected none", resp_id);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({resp_ok, resp_id, resp_width} != e) begin
                        errors++;
                        $display("FAIL resp actual ok=%0d id=%0d w=%0d expected ok=%0d id=%0d w=%0d",
                                 resp_ok, resp_id, resp_width, e.ok, e.id, e.w);
                    end
                end
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        ok = req_ready;
        if (!ok) chk("req_ready_timeout", 0, 1);
    endtask

    task automatic do_req(input int w);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        exp_q.push_back(model_place(w));
        req_valid = 1'b1; req_width = 7'(w);
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (LAT - 1) @(posedge clk);
        #1 chk("latency_early", int'(resp_valid), 0);
        @(posedge clk);
        #1 chk("latency_rise", int'(resp_valid), 1);
    endtask

    task automatic start_raw(input int w);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        req_valid = 1'b1; req_width = 7'(w);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin @(negedge clk); n++; end
        if (busy || exp_q.size() != 0) chk("idle_timeout", 0, 1);
    endtask

    task automatic do_clear();
        wait_idle();
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        model_clear();
    endtask

    initial begin
        model_clear();
        #23 rst = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_resp_ok", int'(resp_ok), 0);
        chk("rst_resp_id", int'(resp_id), 15);
        chk("rst_resp_width", int'(resp_width), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_req_ready", int'(req_ready), 1);

        repeat (4) do_req(40);
        do_clear();
        do_req(90);
        do_req(10);
        do_clear();
        repeat (NS) do_req(90);
        do_req(60);
        do_clear();
        repeat (NS) do_req(10);
        do_req(5);
        do_clear();
        do_req(101);
        do_req(127);
        do_req(0);
        do_req(100);

        wait_idle();
        hold_rdy = 1'b1;
        @(posedge clk);
        do_req(33);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_valid", int'(resp_valid), 1);
            chk("hold_req_ready", int'(req_ready), 0);
            if (exp_q.size() != 0)
                chk("hold_outputs", int'({resp_ok, resp_id, resp_width}), int'(exp_q[0]));
        end
        hold_rdy = 1'b0;

        wait_idle();
        start_raw(20);
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        model_clear();
        chk("clear_busy", int'(busy), 0);
        chk("clear_valid", int'(resp_valid), 0);
        repeat (8) @(posedge clk);
        do_req(7);

        wait_idle();
        start_raw(15);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("arst_id", int'(resp_id), 15);
        chk("arst_busy", int'(busy), 0);
        chk("arst_width", int'(resp_width), 0);
        #2 rst = 1'b0;
        model_clear();
        do_req(9);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 14) == 0) do_clear();
            if ($urandom_range(0, 9) == 0) do_req($urandom_range(95, 127));
            else do_req($urandom_range(0, 50));
        end

        wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
